// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect, flush generation and parking of a
// redirect that arrives while instruction memory holds fetch. Optional BRANCH_STATS_EN adds branch counters.
module pc_redirect_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Branch,
  input  logic            Btaken,
  input  logic            Jump,
  input  logic [XLEN-1:0] target_addr,
  input  logic            hazard_stall,
  input  logic            fetch_hold,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus4,
  output logic            flush_IFID,
  output logic            flush_IDEX,
  output logic            redirect_pending,
  output logic            misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     taken_cnt
`endif
);

  typedef enum logic {
    NORMAL  = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] parked_q, parked_d;
  logic [XLEN-1:0] eff_target;
  logic            redirect;
  logic            misalign_q;
  logic            flush_ifid_c, flush_idex_c;

  // Bit 0 of the target is never used; Branch only feeds the optional counters.
  logic            unused_inputs;
  assign unused_inputs = ^{Branch, target_addr[0]};

  assign redirect   = Btaken | Jump;
  assign eff_target = {target_addr[XLEN-1:1], 1'b0};

  // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    parked_d     = parked_q;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;

    unique case (state_q)
      NORMAL: begin
        if (redirect) begin
          // Redirect beats hazard_stall: the stalled instruction is wrong-path anyway.
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          if (fetch_hold) begin
            parked_d = eff_target;
            state_d  = PENDING;
          end else begin
            pc_d = eff_target;
          end
        end else if (!(hazard_stall || fetch_hold)) begin
          pc_d = pc_q + XLEN'(4);
        end
      end

      PENDING: begin
        // Anything fetched while parked is wrong-path and must never reach ID.
        flush_ifid_c = 1'b1;
        if (redirect) begin
          flush_idex_c = 1'b1;
          parked_d     = eff_target;
        end
        if (!fetch_hold) begin
          pc_d    = redirect ? eff_target : parked_q;
          state_d = NORMAL;
        end
      end

      default: state_d = NORMAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= NORMAL;
      pc_q       <= RESET_PC;
      parked_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      parked_q   <= parked_d;
      misalign_q <= redirect & target_addr[1];
    end
  end

  assign PC               = pc_q;
  assign PC_plus4         = pc_q + XLEN'(4);
  assign flush_IFID       = reset_n & flush_ifid_c;
  assign flush_IDEX       = reset_n & flush_idex_c;
  assign redirect_pending = (state_q == PENDING);
  assign misalign         = misalign_q;

`ifdef BRANCH_STATS_EN
  // An EX instruction retires its branch once it is not held, or when it redirects.
  logic ex_advance;
  assign ex_advance = (~hazard_stall & ~fetch_hold) | redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (Branch && ex_advance) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (Btaken) taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus random stimulus
// compared against a behavioural model of fetch PC, parked redirect and flushes.
module tb_pc_redirect_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            Branch, Btaken, Jump, hazard_stall, fetch_hold;
  logic [XLEN-1:0] target_addr;
  logic [XLEN-1:0] PC, PC_plus4;
  logic            flush_IFID, flush_IDEX, redirect_pending, misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0]     branch_cnt, taken_cnt;
`endif

  pc_redirect_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .Branch           (Branch),
    .Btaken           (Btaken),
    .Jump             (Jump),
    .target_addr      (target_addr),
    .hazard_stall     (hazard_stall),
    .fetch_hold       (fetch_hold),
    .PC               (PC),
    .PC_plus4         (PC_plus4),
    .flush_IFID       (flush_IFID),
    .flush_IDEX       (flush_IDEX),
    .redirect_pending (redirect_pending),
    .misalign         (misalign)
`ifdef BRANCH_STATS_EN
    ,
    .branch_cnt       (branch_cnt),
    .taken_cnt        (taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_park, m_bcnt, m_tcnt;
  logic        m_pend, m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_park = '0;
    m_pend = 1'b0;
    m_mis  = 1'b0;
    m_bcnt = '0;
    m_tcnt = '0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_pc"},       PC, m_pc);
    check({pfx, "_pcplus4"},  PC_plus4, m_pc + 32'd4);
    check({pfx, "_pending"},  {31'd0, redirect_pending}, {31'd0, m_pend});
    check({pfx, "_misalign"}, {31'd0, misalign}, {31'd0, m_mis});
`ifdef BRANCH_STATS_EN
    check({pfx, "_bcnt"},     branch_cnt, m_bcnt);
    check({pfx, "_tcnt"},     taken_cnt, m_tcnt);
`endif
  endtask

  // Drive one cycle at the negedge, check outputs before the edge, advance the model.
  task automatic cycle(input logic br, input logic bt, input logic jp,
                       input logic [31:0] ta, input logic hs, input logic fh);
    logic        redir;
    logic [31:0] eff;
    Branch = br; Btaken = bt; Jump = jp; target_addr = ta;
    hazard_stall = hs; fetch_hold = fh;
    #1;
    redir = bt | jp;
    eff   = {ta[31:1], 1'b0};
    check_regs("cyc");
    check("cyc_flush_ifid", {31'd0, flush_IFID}, {31'd0, redir | m_pend});
    check("cyc_flush_idex", {31'd0, flush_IDEX}, {31'd0, redir});
    if (br && ((!hs && !fh) || redir)) begin
      m_bcnt++;
      if (bt) m_tcnt++;
    end
    m_mis = redir & ta[1];
    if (m_pend) begin
      if (redir) m_park = eff;
      if (!fh) begin
        m_pc   = m_park;
        m_pend = 1'b0;
      end
    end else if (redir) begin
      if (fh) begin
        m_park = eff;
        m_pend = 1'b1;
      end else begin
        m_pc = eff;
      end
    end else if (!(hs || fh)) begin
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jump_to(input logic [31:0] a);
    cycle(1'b0, 1'b0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    Btaken  = 1'b1;
    Jump    = 1'b1;
    #1;
    model_reset();
    check("rst_flush_ifid", {31'd0, flush_IFID}, 32'd0);
    check("rst_flush_idex", {31'd0, flush_IDEX}, 32'd0);
    check_regs("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    Branch = 0; Btaken = 0; Jump = 0; target_addr = '0;
    hazard_stall = 0; fetch_hold = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Free run from reset: 0, 4, 8, C
    for (int i = 0; i < 4; i++) begin
      check("run_pc", PC, 32'(i * 4));
      idle();
    end
    check("run_pc_10", PC, 32'h10);

    // Taken branch from 0x10
    cycle(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
    check("br_pc", PC, 32'h100);
    idle();

    // Jump beats hazard_stall; bit0 cleared, bit1 clear -> no misalign
    jump_to(32'h20);
    cycle(1'b0, 1'b0, 1'b1, 32'h41, 1'b1, 1'b0);
    check("jmp_stall_pc", PC, 32'h40);
    check("jmp_stall_mis", {31'd0, misalign}, 32'd0);

    // Redirect under fetch_hold parks target
    jump_to(32'h30);
    cycle(1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("park_pc", PC, 32'h30);
    check("park_pending", {31'd0, redirect_pending}, 32'd1);
    idle();
    check("unpark_pc", PC, 32'h200);
    check("unpark_pending", {31'd0, redirect_pending}, 32'd0);

    // Wrap-around and misaligned jump target
    jump_to(32'hFFFF_FFFC);
    idle();
    check("wrap_pc", PC, 32'h0);
    jump_to(32'h102);
    check("mis_pc", PC, 32'h102);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    idle();
    check("mis_clear", {31'd0, misalign}, 32'd0);

    // Reset in PENDING discards the parked target
    cycle(1'b0, 1'b0, 1'b1, 32'h800, 1'b0, 1'b1);
    do_reset();
    idle();
    check("rst_pend_pc", PC, 32'h4);

    // Randomized stimulus
    for (int n = 0; n < 3000; n++) begin
      logic br, bt, jp, hs, fh;
      br = ($urandom_range(0, 99) < 25);
      bt = br & ($urandom_range(0, 1) == 1);
      jp = ($urandom_range(0, 99) < 8);
      hs = ($urandom_range(0, 99) < 20);
      fh = ($urandom_range(0, 99) < 35);
      cycle(br, bt, jp, $urandom(), hs, fh);
      if (n == 1500) do_reset();
    end

`ifdef BRANCH_STATS_EN
    // Three branches (two taken); one repeated under hazard_stall
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0);
    check("stats_branch", branch_cnt, 32'd3);
    check("stats_taken", taken_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Fetch-side PC register and control-transfer redirect stage; consumes Btaken from the branch decision logic and jump/target information from EX. Generates the next fetch PC and the flush pulses for the IF/ID and ID/EX pipeline registers. Handles a redirect that arrives while instruction memory is holding fetch by parking the target until fetch resumes.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
Branch  input  1  EX holds a conditional branch (statistics only).
Btaken  input  1  EX branch resolved taken (already gated by Branch).
Jump  input  1  EX holds jal/jalr; unconditional redirect.
target_addr  input  XLEN  redirect target computed in EX.
hazard_stall  input  1  load-use stall from hazard unit; hold PC.
fetch_hold  input  1  instruction memory not ready; hold PC.
PC  output  XLEN  current fetch address (registered).
PC_plus4  output  XLEN  PC + 4, combinational.
flush_IFID  output  1  clear IF/ID register at next edge.
flush_IDEX  output  1  clear ID/EX register at next edge.
redirect_pending  output  1  high in PENDING state.
misalign  output  1  registered one-cycle pulse: redirect target bit1 was set.

Behaviour:
- Async reset (reset_n low): PC=RESET_PC, state=NORMAL, pending target=0, misalign=0; flush_IFID=flush_IDEX=0 while in reset; redirect_pending=0. Reset mid-PENDING discards parked target.
- redirect = Btaken | Jump. Effective target = {target_addr[XLEN-1:1], 1'b0} (bit0 always cleared).
- PC_plus4 = PC + 4, modulo 2^XLEN (wrap from 32'hFFFF_FFFC to 0, no flag).
- States: NORMAL, PENDING.
- NORMAL, per cycle (priority top-down):
  - redirect & ~fetch_hold: PC <= effective target; flush_IFID=1, flush_IDEX=1 this cycle; stay NORMAL. Redirect overrides hazard_stall (stalled instruction is wrong-path).
  - redirect & fetch_hold: parked target <= effective target; PC holds; flush_IFID=1, flush_IDEX=1 this cycle; -> PENDING.
  - ~redirect & (hazard_stall | fetch_hold): PC holds; flushes 0.
  - otherwise: PC <= PC + 4; flushes 0.
- PENDING, per cycle:
  - flush_IFID=1 every cycle (wrong-path fetch must not enter ID); flush_IDEX=0 unless a redirect occurs.
  - redirect (should not occur, EX is flushed): parked target overwritten with new effective target, flush_IDEX=1; newest wins.
  - fetch_hold=1: PC holds, stay PENDING.
  - fetch_hold=0: PC <= parked target (or new target if redirect same cycle); -> NORMAL. hazard_stall ignored in PENDING.
- misalign: registered; set for exactly one cycle after any cycle with redirect & target_addr[1]=1; redirect still performed. Exception handling is downstream.
- Flush outputs are combinational from state and inputs; PC and misalign are registered; latency redirect -> PC visible = 1 cycle (NORMAL, no hold).

Optional Feature:
BRANCH_STATS_EN: when defined, adds outputs branch_cnt[31:0] and taken_cnt[31:0]. branch_cnt increments on every cycle with Branch=1 in which the EX instruction is not held (~hazard_stall & ~fetch_hold, or redirect); taken_cnt increments on the same condition with Btaken=1. Both reset to 0 on reset_n low, wrap at 2^32. Without the macro: ports absent, no counter logic; Branch input unused.

Test Plan:
Reset release, no stalls, no redirect, 4 cycles -> PC 0x0, 0x4, 0x8, 0xC; flushes 0.
PC=0x10, Btaken=1, target_addr=0x100, no holds -> flush_IFID=flush_IDEX=1 that cycle; next cycle PC=0x100, flushes 0.
PC=0x20, hazard_stall=1 and Jump=1 target=0x41 same cycle -> redirect wins; next PC=0x40, misalign=0 (bit1 clear).
PC=0x30, fetch_hold=1, Btaken=1 target=0x200, hold for 3 more cycles -> redirect_pending=1, PC stays 0x30, flush_IFID=1 each cycle; fetch_hold drops -> next PC=0x200, state NORMAL.
PC=0xFFFF_FFFC free-running -> next PC=0x0; Jump target 0x102 -> PC=0x102, misalign pulses 1 for one cycle.
With BRANCH_STATS_EN: 3 branches (2 taken, 1 not), one repeated under hazard_stall -> branch_cnt=3, taken_cnt=2.
